// File: rtl/arcade_input_ctrl_if.sv
// Player-input bundle between mist_io/keyboard and the galaxian core.
// The master side drives raw inputs; the slave side returns conditioned ports.
interface arcade_input_ctrl_if;
    logic       vblank;
    logic       rotate;
    logic [9:0] kbjoy;
    logic [7:0] joystick_0;
    logic [7:0] joystick_1;
    logic [6:0] p1_csjudlr;
    logic [6:0] p2_csjudlr;
    logic       coin_busy;

    modport master (
        output vblank, rotate, kbjoy, joystick_0, joystick_1,
        input  p1_csjudlr, p2_csjudlr, coin_busy
    );

    modport slave (
        input  vblank, rotate, kbjoy, joystick_0, joystick_1,
        output p1_csjudlr, p2_csjudlr, coin_busy
    );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Input conditioner: merge, rotate, SOCD-clean, frame-timed coin pulses.
// Optional autofire on kbjoy[8] when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_ctrl #(
    parameter int COIN_FRAMES = 3,
    parameter int COIN_GAP    = 2,
    parameter int AF_FRAMES   = 4
) (
    input logic             clk_sys,
    input logic             reset,
    arcade_input_ctrl_if.slave io
);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_st_t;

    localparam logic [7:0] CF_LOAD = 8'(COIN_FRAMES);
    localparam logic [7:0] CG_LOAD = 8'(COIN_GAP);

    logic [7:0] kb_s;
    logic [4:0] j0_s, j1_s;
    logic       rot_s, coin_d;
    logic       vb_s1, vb_s2, vb_d;
    logic       frame_tick, coin_edge;
    logic [4:0] jor;
    logic       up_r, down_r, left_r, right_r;
    logic [3:0] dirs;
    logic       fire_man, fire;
    logic [5:0] p1_q, p2_q;
    logic       coin_q;
    coin_st_t   st, st_n;
    logic [7:0] cnt, cnt_n;
    logic       pend, pend_n;
    logic       unused_bits;

    // Coin history resets high so a key held through reset never counts.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            kb_s   <= 8'h08;
            coin_d <= 1'b1;
            j0_s   <= '0;
            j1_s   <= '0;
            rot_s  <= 1'b0;
            vb_s1  <= 1'b0;
            vb_s2  <= 1'b0;
            vb_d   <= 1'b0;
        end else begin
            kb_s   <= io.kbjoy[7:0];
            coin_d <= kb_s[3];
            j0_s   <= io.joystick_0[4:0];
            j1_s   <= io.joystick_1[4:0];
            rot_s  <= io.rotate;
            vb_s1  <= io.vblank;
            vb_s2  <= vb_s1;
            vb_d   <= vb_s2;
        end
    end

    assign frame_tick = vb_s2 & ~vb_d;
    assign coin_edge  = kb_s[3] & ~coin_d;
    assign jor        = j0_s | j1_s;

    always_comb begin
        if (rot_s) begin
            up_r    = kb_s[6] | jor[1];
            down_r  = kb_s[7] | jor[0];
            left_r  = kb_s[5] | jor[2];
            right_r = kb_s[4] | jor[3];
        end else begin
            up_r    = kb_s[4] | jor[3];
            down_r  = kb_s[5] | jor[2];
            left_r  = kb_s[6] | jor[1];
            right_r = kb_s[7] | jor[0];
        end
    end

    // Opposing directions cancel each other out.
    assign dirs = {up_r & ~down_r, down_r & ~up_r,
                   left_r & ~right_r, right_r & ~left_r};
    assign fire_man = kb_s[0] | jor[4];

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic       kb8_s, kb8_d, af_phase;
    logic [7:0] af_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            kb8_s    <= 1'b0;
            kb8_d    <= 1'b0;
            af_phase <= 1'b0;
            af_cnt   <= '0;
        end else begin
            kb8_s <= io.kbjoy[8];
            kb8_d <= kb8_s;
            if (!kb8_s) begin
                af_phase <= 1'b0;
                af_cnt   <= '0;
            end else if (!kb8_d) begin
                af_phase <= 1'b1;
                af_cnt   <= 8'(AF_FRAMES);
            end else if (frame_tick) begin
                if (af_cnt <= 8'd1) begin
                    af_phase <= ~af_phase;
                    af_cnt   <= 8'(AF_FRAMES);
                end else begin
                    af_cnt <= af_cnt - 8'd1;
                end
            end
        end
    end

    assign fire        = fire_man | (kb8_s & af_phase);
    assign unused_bits = ^{io.kbjoy[9], io.joystick_0[7:5],
                           io.joystick_1[7:5]};
`else
    assign fire        = fire_man;
    assign unused_bits = ^{io.kbjoy[9:8], io.joystick_0[7:5],
                           io.joystick_1[7:5], 8'(AF_FRAMES)};
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            st   <= IDLE;
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            st   <= st_n;
            cnt  <= cnt_n;
            pend <= pend_n;
        end
    end

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        pend_n = pend;
        case (st)
            IDLE: begin
                if (coin_edge || pend) begin
                    st_n   = PULSE;
                    cnt_n  = CF_LOAD;
                    pend_n = pend & coin_edge;
                end
            end
            PULSE: begin
                if (coin_edge) pend_n = 1'b1;
                if (frame_tick) begin
                    if (cnt <= 8'd1) begin
                        st_n  = GAP;
                        cnt_n = CG_LOAD;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            GAP: begin
                if (coin_edge) pend_n = 1'b1;
                if (frame_tick) begin
                    if (cnt <= 8'd1) begin
                        st_n  = IDLE;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            default: begin
                st_n  = IDLE;
                cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p1_q   <= '0;
            p2_q   <= '0;
            coin_q <= 1'b0;
        end else begin
            p1_q   <= {kb_s[1], fire, dirs};
            p2_q   <= {kb_s[2], fire, dirs};
            coin_q <= (st == PULSE);
        end
    end

    assign io.p1_csjudlr = {coin_q, p1_q};
    assign io.p2_csjudlr = {1'b0, p2_q};
    assign io.coin_busy  = (st != IDLE);

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: 16-cycle frames, directed vectors.
// Expectations are queued by the stimulus and checked by a negedge monitor.
module tb_arcade_input_ctrl;

    typedef struct {
        int         at;
        logic [6:0] p1;
        logic [6:0] p2;
        logic       busy;
        string      name;
    } exp_t;

    logic clk_sys;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    logic vb_en;
    logic vb_idle;
    exp_t q[$];
    exp_t e;

    arcade_input_ctrl_if bus ();

    arcade_input_ctrl dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .io      (bus)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // vblank high for the first 4 cycles of every 16-cycle frame
    initial begin
        forever begin
            @(negedge clk_sys);
            bus.vblank = vb_en ? ((cyc % 16) < 4) : vb_idle;
        end
    end

    task automatic exp(input int at, input logic [6:0] p1,
                       input logic [6:0] p2, input logic b,
                       input string nm);
        q.push_back('{at, p1, p2, b, nm});
    endtask

    task automatic at_cyc(input int c);
        @(negedge clk_sys);
        while (cyc < c) @(negedge clk_sys);
    endtask

    task automatic press_coin(input int c);
        at_cyc(c);
        bus.kbjoy = 10'h008;
        at_cyc(c + 1);
        bus.kbjoy = 10'h000;
    endtask

    always @(negedge clk_sys) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.at != cyc) begin
                bad++;
                $display("FAIL %s slot missed at=%0d now=%0d",
                         e.name, e.at, cyc);
            end else if ({bus.p1_csjudlr, bus.p2_csjudlr, bus.coin_busy}
                         !== {e.p1, e.p2, e.busy}) begin
                bad++;
                $display("FAIL %s cyc=%0d got p1=%b p2=%b busy=%b want p1=%b p2=%b busy=%b",
                         e.name, cyc, bus.p1_csjudlr, bus.p2_csjudlr,
                         bus.coin_busy, e.p1, e.p2, e.busy);
            end
        end
    end

    initial begin
        logic af;
        logic [6:0] fv;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        af = 1'b1;
`else
        af = 1'b0;
`endif
        total = 0;
        bad   = 0;

        // reset with every input held high
        reset          = 1'b1;
        vb_en          = 1'b0;
        vb_idle        = 1'b1;
        bus.vblank     = 1'b1;
        bus.rotate     = 1'b1;
        bus.kbjoy      = 10'h3ff;
        bus.joystick_0 = 8'hff;
        bus.joystick_1 = 8'hff;
        for (int i = 1; i <= 4; i++) exp(i, 7'h00, 7'h00, 1'b0, "rst_zero");
        exp(5, 7'h00, 7'h00, 1'b0, "rst_latency");
        exp(6, 7'h30, 7'h30, 1'b0, "held_no_coin");
        exp(7, 7'h30, 7'h30, 1'b0, "held_no_coin");
        exp(11, 7'h30, 7'h30, 1'b0, "held_no_coin");
        at_cyc(4);
        reset = 1'b0;
        at_cyc(12);
        bus.kbjoy      = 10'h000;
        bus.joystick_0 = 8'h00;
        bus.joystick_1 = 8'h00;
        vb_idle        = 1'b0;
        exp(14, 7'h00, 7'h00, 1'b0, "all_clear");

        // rotation
        at_cyc(16);
        exp(17, 7'h00, 7'h00, 1'b0, "rot_latency");
        exp(18, 7'h08, 7'h08, 1'b0, "rot1_up");
        exp(21, 7'h08, 7'h08, 1'b0, "rot_sync_lag");
        exp(22, 7'h02, 7'h02, 1'b0, "rot0_left");
        bus.rotate     = 1'b1;
        bus.joystick_0 = 8'h02;
        at_cyc(20);
        bus.rotate = 1'b0;

        // SOCD, fire and starts
        at_cyc(24);
        exp(26, 7'h00, 7'h00, 1'b0, "socd_ud");
        bus.joystick_0 = 8'h0c;
        at_cyc(28);
        exp(30, 7'h02, 7'h02, 1'b0, "socd_plus_left");
        bus.kbjoy = 10'h040;
        at_cyc(32);
        exp(34, 7'h00, 7'h00, 1'b0, "socd_lr");
        bus.joystick_1 = 8'h03;
        at_cyc(36);
        exp(38, 7'h30, 7'h10, 1'b0, "fire_start1");
        bus.kbjoy      = 10'h003;
        bus.joystick_0 = 8'h00;
        bus.joystick_1 = 8'h00;
        at_cyc(40);
        exp(42, 7'h00, 7'h20, 1'b0, "start2");
        bus.kbjoy = 10'h004;
        at_cyc(44);
        exp(46, 7'h10, 7'h10, 1'b0, "j1_fire");
        bus.kbjoy      = 10'h000;
        bus.joystick_1 = 8'h10;
        at_cyc(48);
        exp(50, 7'h00, 7'h00, 1'b0, "idle");
        bus.joystick_1 = 8'h00;
        at_cyc(52);
        vb_en = 1'b1;

        // single coin: ticks act at 16f+3
        exp(66, 7'h00, 7'h00, 1'b0, "c_idle");
        exp(73, 7'h00, 7'h00, 1'b0, "c_edge");
        exp(74, 7'h00, 7'h00, 1'b1, "c_enter");
        exp(75, 7'h40, 7'h00, 1'b1, "c_rise");
        exp(82, 7'h40, 7'h00, 1'b1, "c_tick1");
        exp(114, 7'h40, 7'h00, 1'b1, "c_tick3");
        exp(115, 7'h40, 7'h00, 1'b1, "c_last");
        exp(116, 7'h00, 7'h00, 1'b1, "c_fall");
        exp(130, 7'h00, 7'h00, 1'b1, "c_gap1");
        exp(146, 7'h00, 7'h00, 1'b1, "c_gap2");
        exp(147, 7'h00, 7'h00, 1'b0, "c_done");
        exp(162, 7'h00, 7'h00, 1'b0, "c_stay_idle");
        press_coin(72);

        // three presses -> two pulses; reset kills the second
        exp(185, 7'h00, 7'h00, 1'b0, "q_edge");
        exp(186, 7'h00, 7'h00, 1'b1, "q_enter1");
        exp(187, 7'h40, 7'h00, 1'b1, "q_rise1");
        exp(226, 7'h40, 7'h00, 1'b1, "q_hold1");
        exp(228, 7'h00, 7'h00, 1'b1, "q_gap");
        exp(242, 7'h00, 7'h00, 1'b1, "q_gap");
        exp(258, 7'h00, 7'h00, 1'b1, "q_gap_end");
        exp(259, 7'h00, 7'h00, 1'b0, "q_idle");
        exp(260, 7'h00, 7'h00, 1'b1, "q_enter2");
        exp(261, 7'h40, 7'h00, 1'b1, "q_rise2");
        exp(280, 7'h40, 7'h00, 1'b1, "q_hold2");
        exp(281, 7'h00, 7'h00, 1'b0, "q_rst_abort");
        for (int k = 0; k < 4; k++)
            exp(290 + 16 * k, 7'h00, 7'h00, 1'b0, "q_no_third");
        press_coin(184);
        press_coin(190);
        press_coin(200);
        press_coin(270);
        at_cyc(280);
        reset = 1'b1;
        at_cyc(282);
        reset = 1'b0;

        // autofire: 4 frames on, 4 frames off
        for (int k = 0; k < 16; k++) begin
            fv = (af && ((k / 4) % 2 == 0)) ? 7'h10 : 7'h00;
            exp(368 + 16 * k, fv, fv, 1'b0, "af_frame");
        end
        exp(616, 7'h00, 7'h00, 1'b0, "af_release");
        at_cyc(360);
        bus.kbjoy = 10'h100;
        at_cyc(612);
        bus.kbjoy = 10'h000;

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk_sys);
        if (q.size() > 0) begin
            $display("FAIL drain pending=%0d want 0", q.size());
            bad += q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
